// File: rtl/apb_master_if.sv
// Command/response handshake plus APB bus bundle for apb_master.
// master = requester view (the design), slave = command source / APB peripheral view.
interface apb_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester; response 3+N cycles after accept (N = wait states), timeout after T ACCESS cycles.
// rsp_ready low holds the response stable and keeps req_ready low until the handshake.
module apb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          n_rst,
  apb_master_if.master bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  state_t        state;
  cmd_t          cmd;
  logic          psel;
  logic          penable;
  logic          rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_rdata;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cmd       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cmd      <= {bus.req_write, bus.req_addr, bus.req_wdata};
            wait_cnt <= '0;
            psel     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A completing PREADY takes priority over a timeout in the same cycle.
          if (bus.PREADY) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= cmd.write ? '0 : bus.PRDATA;
            rsp_err   <= bus.PSLVERR;
            state     <= RESP;
          end else if (TO_EN && wait_cnt == CNT_LAST) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = cmd.write;
  assign bus.PADDR     = cmd.addr;
  assign bus.PWDATA    = cmd.wdata;
endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: issue pushes expected response, negedge monitor checks APB phases and responses.
module tb_apb_master;
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  apb_master_if bus();
  apb_master #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n_access;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          slv_waits = 0;
  bit          slv_never = 1'b0;
  bit          slv_err = 1'b0;
  bit          slv_err_in_wait = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          slv_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  // APB slave model: PREADY on ACCESS cycle slv_waits+1; PRDATA/PSLVERR garbage outside that cycle.
  initial begin
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 32'h0BAD_0BAD;
    forever begin
      @(posedge clk);
      #1;
      if (bus.PSEL && bus.PENABLE) slv_cnt++;
      else slv_cnt = 0;
      bus.PREADY  = !slv_never && bus.PSEL && bus.PENABLE && (slv_cnt == slv_waits + 1);
      bus.PRDATA  = bus.PREADY ? slv_rdata : 32'h0BAD_0BAD;
      bus.PSLVERR = bus.PREADY ? slv_err : (slv_err_in_wait && bus.PSEL && bus.PENABLE);
    end
  end

  int setup_n = 0;
  int acc_n = 0;
  int acc_cyc = 0;
  bit rsp_seen = 1'b0;
  bit rdy_next = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        setup_n = 0; acc_n = 0; rsp_seen = 1'b0; rdy_next = 1'b0;
      end else begin
        if (rdy_next) begin
          chk1("req_ready_after_rsp", bus.req_ready, 1'b1);
          rdy_next = 1'b0;
        end
        if (bus.req_valid && bus.req_ready) begin
          acc_cyc = cyc; setup_n = 0; acc_n = 0;
        end
        if (bus.PSEL) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL apb_unexpected: got PSEL=1 at addr %h, required no transfer", bus.PADDR);
          end else begin
            if (!bus.PENABLE) setup_n++;
            else acc_n++;
            chk("paddr", bus.PADDR, sb[0].addr);
            chk1("pwrite", bus.PWRITE, sb[0].write);
            chk("pwdata", bus.PWDATA, sb[0].wdata);
          end
        end
        if (bus.rsp_valid) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 rdata %h, required no response", bus.rsp_rdata);
          end else begin
            if (!rsp_seen) begin
              rsp_seen = 1'b1;
              chk("rsp_latency", cyc - acc_cyc, sb[0].lat);
              chk("setup_cycles", setup_n, 1);
              chk("access_cycles", acc_n, sb[0].n_access);
              chk1("psel_in_resp", bus.PSEL | bus.PENABLE, 1'b0);
            end
            chk("rsp_rdata", bus.rsp_rdata, sb[0].rdata);
            chk1("rsp_err", bus.rsp_err, sb[0].err);
            chk1("req_ready_in_resp", bus.req_ready, 1'b0);
            if (bus.rsp_ready) begin
              void'(sb.pop_front());
              rsp_seen = 1'b0;
              rdy_next = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat, input int n_acc);
    exp_t e;
    e.write = wr; e.addr = addr; e.wdata = wdata;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = lat; e.n_access = n_acc;
    @(posedge clk);
    #1;
    sb.push_back(e);
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready && n_rst) begin
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL req_accept: got req_ready=0 for 300 cycles at addr %h, required acceptance", addr);
    bus.req_valid = 1'b0;
    void'(sb.pop_back());
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) return;
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL %s_done: got %0d responses outstanding, required 0", nm, sb.size());
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk1("rst_rsp_err", bus.rsp_err, 1'b0);
    chk1("rst_psel", bus.PSEL, 1'b0);
    chk1("rst_penable", bus.PENABLE, 1'b0);
    chk1("rst_pwrite", bus.PWRITE, 1'b0);
    chk("rst_paddr", bus.PADDR, 32'h0);
    chk("rst_pwdata", bus.PWDATA, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // zero-wait write: rdata forced to 0 even though PRDATA is non-zero
    slv_waits = 0; slv_rdata = 32'h1111_2222;
    issue(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 32'h0, 1'b0, 3, 1);
    wait_done("wr_zero_wait");

    slv_waits = 2; slv_rdata = 32'hDEAD_BEEF;
    issue(1'b0, 32'h0000_0004, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 5, 3);
    wait_done("rd_two_wait");

    slv_waits = 0; slv_err = 1'b1; slv_rdata = 32'hCAFE_F00D;
    issue(1'b0, 32'h0000_0020, 32'h5555_0000, 32'hCAFE_F00D, 1'b1, 3, 1);
    wait_done("rd_slverr");
    slv_err = 1'b0;

    // PSLVERR pulsed only during wait cycles must not leak into the response
    slv_waits = 3; slv_err_in_wait = 1'b1; slv_rdata = 32'h0123_4567;
    issue(1'b0, 32'h0000_0024, 32'h0000_0000, 32'h0123_4567, 1'b0, 6, 4);
    wait_done("rd_err_in_wait");
    slv_err_in_wait = 1'b0;

    slv_waits = 1; slv_err = 1'b1; slv_rdata = 32'h9999_9999;
    issue(1'b1, 32'h0000_0030, 32'hFFFF_0001, 32'h0, 1'b1, 4, 2);
    wait_done("wr_slverr");
    slv_err = 1'b0;

    slv_never = 1'b1;
    issue(1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0, 1'b1, 18, 16);
    wait_done("rd_timeout");
    slv_never = 1'b0;

    slv_waits = 15; slv_rdata = 32'h600D_600D;
    issue(1'b0, 32'h0000_0044, 32'h0000_0000, 32'h600D_600D, 1'b0, 18, 16);
    wait_done("rd_ready_at_limit");

    // backpressure with a second command held until the response handshake
    slv_waits = 0; slv_rdata = 32'h1234_5678;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0050, 32'h0000_0000, 32'h1234_5678, 1'b0, 3, 1);
    fork
      issue(1'b1, 32'h0000_0054, 32'h0BEE_F00D, 32'h0, 1'b0, 3, 1);
      begin : bp
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
          @(negedge clk);
          got = bus.rsp_valid;
        end
        if (!got) begin
          checks++; errors++;
          $display("FAIL bp_rsp_valid: got no rsp_valid in 50 cycles, required response");
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
      end
    join
    wait_done("backpressure");

    // reset in the middle of a stalled ACCESS
    slv_never = 1'b1;
    issue(1'b0, 32'h0000_0060, 32'h0000_0000, 32'h0, 1'b0, 0, 0);
    begin : find_access
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = bus.PSEL && bus.PENABLE;
      end
      chk1("mid_rst_access_seen", seen, 1'b1);
    end
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk1("mid_rst_psel", bus.PSEL, 1'b0);
    chk1("mid_rst_penable", bus.PENABLE, 1'b0);
    chk1("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("mid_rst_req_ready", bus.req_ready, 1'b1);
    chk("mid_rst_paddr", bus.PADDR, 32'h0);
    sb.delete();
    slv_never = 1'b0;
    @(posedge clk);
    #3 n_rst = 1'b1;

    slv_waits = 1; slv_rdata = 32'h7777_8888;
    issue(1'b0, 32'h0000_0064, 32'h0000_0000, 32'h7777_8888, 1'b0, 4, 2);
    wait_done("after_reset");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that turns a valid/ready command interface into APB SETUP/ACCESS transfers and returns read data and error status on a valid/ready response interface. It is the initiator end of the peripheral bus the I2C and other APB slave blocks sit on. It lets internal engines, bench drivers and DMA-style sequencers program those peripherals without bus-level code. PREADY wait states, PSLVERR and a wait-state timeout are all handled.

## Interface
- TIMEOUT_CYCLES, 16: max ACCESS cycles without PREADY before abort; 0 disables timeout
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  asynchronous active-low reset
- req_valid  input  1  command present
- req_ready  output  1  block can accept command
- req_write  input  1  1 = write, 0 = read
- req_addr  input  32  target address
- req_wdata  input  32  write data (ignored for reads)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  32  read data; 0 for writes and timeouts
- rsp_err  output  1  PSLVERR sampled, or timeout
- PSEL, PENABLE, PWRITE  output  1 each  APB control
- PADDR, PWDATA  output  32 each  APB address / write data
- PRDATA  input  32  APB read data
- PREADY  input  1  APB transfer complete
- PSLVERR  input  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE
  - req_ready = 1; it is combinational from state only.
  - On req_valid: latch write/addr/wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
- SETUP
  - PSEL = 1, PENABLE = 0.
  - Always exactly one cycle, then go to ACCESS.
- ACCESS
  - PSEL = 1, PENABLE = 1.
  - PREADY = 1: capture rsp_rdata (PRDATA if read, else 0) and rsp_err = PSLVERR, then go to RESP.
  - PREADY = 0: increment the wait counter.
  - Timeout: if TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES − 1 while PREADY is still 0, go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - The counter is cleared on entry to SETUP. Its width is clog2(TIMEOUT_CYCLES+1), minimum 1.
- RESP
  - PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - rsp_rdata and rsp_err hold stable until rsp_ready = 1, then go to IDLE.
- PADDR, PWDATA and PWRITE stay stable from SETUP through the final ACCESS cycle. Outside a transfer they retain their last values.
- PSLVERR and PRDATA are sampled only in the ACCESS cycle where PREADY = 1. They are ignored in every other cycle.
- A request presented while req_ready = 0 is not consumed. The requester must hold it stable.
- Only one transfer is outstanding at a time. There is no pipelining of SETUP into RESP.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous), state returns to IDLE, and the in-flight command and response are dropped.

## Timing
- Reset values of outputs:
  - req_ready = 1.
  - All of the following are 0: rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA.
- Command accepted at edge k (req_valid && req_ready):
  - SETUP is in cycle k+1.
  - First ACCESS is in cycle k+2.
- Zero-wait slave (PREADY = 1 in first ACCESS): rsp_valid = 1 in cycle k+3.
- N wait states: rsp_valid = 1 in cycle k+3+N.
- With rsp_ready held at 1, req_ready returns to 1 in cycle k+4+N, giving a minimum 4-cycle command-to-command spacing.
- Timeout with TIMEOUT_CYCLES = T: ACCESS lasts exactly T cycles and rsp_valid = 1 in cycle k+2+T.
- PREADY = 1 in the same cycle the timeout would fire: the PREADY completion wins and rsp_err = PSLVERR.

## Test plan
- Zero-wait write: addr 0x0000_0010, wdata 0xA5A5_5A5A, PREADY = 1.
  - Expect one SETUP and one ACCESS cycle with those values.
  - rsp_valid at k+3 with rsp_err = 0 and rsp_rdata = 0.
- Read with 2 wait states: addr 0x4, PRDATA = 0xDEAD_BEEF on the PREADY cycle.
  - Expect ACCESS held for 3 cycles with PADDR stable.
  - rsp_rdata = 0xDEAD_BEEF at k+5.
- Slave error: read with PREADY = 1 and PSLVERR = 1.
  - Expect rsp_err = 1 with rsp_rdata = PRDATA.
  - PSLVERR pulsed in a wait cycle (PREADY = 0) is ignored.
- Timeout: TIMEOUT_CYCLES = 16, PREADY held at 0.
  - Expect exactly 16 ACCESS cycles, then PSEL drops.
  - rsp_err = 1 and rsp_rdata = 0.
  - Repeat with PREADY = 1 on the 16th cycle: expect rsp_err = 0.
- Backpressure: rsp_ready held at 0 for 5 cycles after rsp_valid.
  - Expect rsp_valid, rsp_rdata and rsp_err stable for those 5 cycles, with req_ready = 0 throughout.
  - A second req_valid held during that time is accepted only after the response handshake.
- Reset mid-access: assert n_rst = 0 during ACCESS with PREADY = 0.
  - Expect PSEL = PENABLE = 0 asynchronously, rsp_valid = 0 and req_ready = 1.
  - The next command completes normally.
